rpsc_seq_ctrl: RTL and testbench
================================

// Module: rpsc_seq_ctrl
// PURPOSE
//  Parametrised, clocked supply sequencer for the RPSC card family. Brings N_SB standby stages up one at a time, then N_HV HV stages.
//  Each enable waits for its active-low ack, then a settle time. Drops supplies in reverse order.
//  Latches trips, ack loss and ack timeouts into a fault state.
//  Drives the active-low SB/HV ON/OFF status lines back to the card backplane.
// PARAMETERS
//  N_SB         4      standby stages; bit 0 enabled first (DR_AMP, FAN, G1, CA)
//  N_HV         2      HV stages; bit 0 enabled first (G2, Anode)
//  SETTLE_CYC   1000   cycles held after ack before next stage (also per-stage step when dropping)
//  TIMEOUT_CYC  50000  max cycles from enable to ack; must be > 0
//  Counter width: localparam CW = $clog2(max(SETTLE_CYC,TIMEOUT_CYC)+1)
// PORTS
//  clk                 in   1     single clock
//  reset               in   1     synchronous, active-high
//  sb_req              in   1     level: 1 = standby wanted
//  hv_req              in   1     level: 1 = HV wanted; ignored unless SB_READY/HV_ON
//  fault_clr           in   1     pulse: clear latched fault
//  i_Not_SB_ACK        in   N_SB  per-stage status, 0 = stage on
//  i_Not_HV_ACK        in   N_HV  per-stage status, 0 = stage on
//  i_Not_ANY_SB_GO_OFF in   1     0 = standby trip
//  i_Not_ANY_HV_GO_OFF in   1     0 = HV trip
//  sb_en               out  N_SB  stage enables, active-high, registered
//  hv_en               out  N_HV  stage enables, active-high, registered
//  o_Not_SB_ON         out  1     registered |i_Not_SB_ACK  (0 = all SB stages on)
//  o_Not_SB_OFF        out  1     registered ~&i_Not_SB_ACK (0 = all SB stages off)
//  o_Not_HV_ON         out  1     registered |i_Not_HV_ACK
//  o_Not_HV_OFF        out  1     registered ~&i_Not_HV_ACK
//  fault               out  1     1 in FAULT or FAULT_HV
//  fault_code          out  2     0 none, 1 SB trip/SB ack loss, 2 ack timeout, 3 HV trip/HV ack loss
//  state               out  3     FSM encoding, for debug
// BEHAVIOUR
//  Reset: state=OFF, sb_en=0, hv_en=0, all o_Not_* = 1, fault=0, fault_code=0, idx=0, cnt=0.
//  Status outputs have 1-cycle latency from the acks. They are independent of the FSM.
//  States: OFF, SB_RAMP, SB_READY, SB_DOWN, HV_RAMP, HV_ON, HV_DOWN, FAULT, FAULT_HV.
//  OFF: sb_req=1 -> SB_RAMP, idx=0. sb_en[0] is set on the same edge, cnt=0.
//  *_RAMP per stage, two phases:
//    Wait phase: cnt increments each cycle. Ack[idx]==0 -> settle phase, cnt=0.
//      If cnt reaches TIMEOUT_CYC with no ack -> fault_code 2.
//    Settle phase: after SETTLE_CYC cycles, idx++ and the next enable is set on that edge.
//      After the last stage -> SB_READY or HV_ON.
//  SB_READY: hv_req=1 -> HV_RAMP (idx=0). sb_req=0 -> SB_DOWN.
//  sb_req=0 in SB_RAMP -> SB_DOWN.
//  hv_req=0 in HV_RAMP/HV_ON -> HV_DOWN. sb_req=0 in HV_RAMP/HV_ON -> HV_DOWN; SB_DOWN follows.
//  *_DOWN: clear the highest set enable immediately, then one more every SETTLE_CYC cycles.
//    Acks are not waited on.
//    Exit when all enables in the group are 0: HV_DOWN -> SB_READY (or SB_DOWN if sb_req=0); SB_DOWN -> OFF.
//  Ack loss: an enabled and already-settled stage whose ack goes to 1 is a trip.
//    Applies to any settled stage while not in a DOWN state.
//  Fault priority (highest first):
//    reset > SB trip (GO_OFF=0 or SB ack loss) > timeout > HV trip (GO_OFF=0 or HV ack loss) > requests.
//  SB trip or timeout, from any non-OFF state:
//    -> FAULT. sb_en and hv_en are cleared on the same edge; code latched.
//  HV trip in HV_RAMP/HV_ON/HV_DOWN -> FAULT_HV: hv_en cleared, sb_en held, code=3.
//  An SB trip in FAULT_HV -> FAULT with code=1 (overwrites).
//  FAULT: exit to OFF only on fault_clr=1 with sb_req=0, hv_req=0, and both GO_OFF inputs =1.
//    fault_code returns to 0 on exit. Otherwise fault_clr is ignored.
//  FAULT_HV: exit to SB_READY on fault_clr=1 with hv_req=0 and i_Not_ANY_HV_GO_OFF=1.
//  GO_OFF inputs low in OFF: no fault; OFF stays until they release and sb_req=1.
//  Requests arriving mid-ramp or mid-drop are sampled only at the transitions listed above.
//  A ramp is never reversed mid-stage except by *_req dropping or a fault.
//  Counters saturate; no wrap.
// TESTING  (bench uses N_SB=4, N_HV=2, SETTLE_CYC=4, TIMEOUT_CYC=10)
//  1. Full up with acks returned 2 cycles after each enable:
//     sb_en 0001->0011->0111->1111 every 7 cycles; SB_READY at cycle 28.
//     o_Not_SB_ON=0 one cycle after the last ack.
//  2. hv_req=1 from SB_READY with acks: hv_en 01->11; HV_ON; o_Not_HV_ON=0.
//     Then hv_req=0: hv_en 01 at +1, 00 at +5; state=SB_READY.
//  3. Ack of stage 2 never returns:
//     fault=1, fault_code=2 exactly 10 cycles after sb_en[2] set; sb_en=0 on that edge.
//  4. i_Not_ANY_HV_GO_OFF=0 in HV_ON: next edge hv_en=00, sb_en=1111, fault_code=3.
//     fault_clr with hv_req=0 -> SB_READY.
//  5. Simultaneous SB and HV GO_OFF low in HV_ON: FAULT with code=1, all enables 0.
//     fault_clr while sb_req=1 is ignored; with sb_req=0 -> OFF.
//  6. reset asserted mid HV_RAMP: next edge all enables 0, all o_Not_*=1, state=OFF, fault=0.

Source files
------------

// File: rtl/rpsc_seq_ctrl.sv
// RPSC supply sequencer. Standby stages come up one at a time, then HV stages, each with
// an ack/settle handshake. Supplies drop in reverse order. Trips, ack loss and ack timeouts latch a fault.
module rpsc_seq_ctrl #(
  parameter int N_SB        = 4,
  parameter int N_HV        = 2,
  parameter int SETTLE_CYC  = 1000,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sb_req,
  input  logic            hv_req,
  input  logic            fault_clr,
  input  logic [N_SB-1:0] i_Not_SB_ACK,
  input  logic [N_HV-1:0] i_Not_HV_ACK,
  input  logic            i_Not_ANY_SB_GO_OFF,
  input  logic            i_Not_ANY_HV_GO_OFF,
  output logic [N_SB-1:0] sb_en,
  output logic [N_HV-1:0] hv_en,
  output logic            o_Not_SB_ON,
  output logic            o_Not_SB_OFF,
  output logic            o_Not_HV_ON,
  output logic            o_Not_HV_OFF,
  output logic            fault,
  output logic [1:0]      fault_code,
  output logic [2:0]      state
);

  localparam int CMAX      = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int CW        = $clog2(CMAX + 1);
  localparam int NMAX      = (N_SB > N_HV) ? N_SB : N_HV;
  localparam int IW        = (NMAX > 1) ? $clog2(NMAX) : 1;
  localparam int DROP_LAST = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;

  typedef enum logic [3:0] {
    S_OFF      = 4'd0,
    S_SB_RAMP  = 4'd1,
    S_SB_READY = 4'd2,
    S_SB_DOWN  = 4'd3,
    S_HV_RAMP  = 4'd4,
    S_HV_ON    = 4'd5,
    S_HV_DOWN  = 4'd6,
    S_FAULT    = 4'd7,
    S_FAULT_HV = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_SB      = 2'd1,
    FC_TIMEOUT = 2'd2,
    FC_HV      = 2'd3
  } fcode_e;

  state_e          state_q, state_d;
  fcode_e          code_q, code_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            settle_q, settle_d;
  logic [N_SB-1:0] sb_en_q, sb_en_d, sb_done_q, sb_done_d;
  logic [N_HV-1:0] hv_en_q, hv_en_d, hv_done_q, hv_done_d;
  logic            sb_on_n_q, sb_off_n_q, hv_on_n_q, hv_off_n_q;

  logic            in_down, is_hv, cur_ack, sb_trip, hv_trip, timeout;
  logic [IW-1:0]   cur_last;
  logic [CW-1:0]   cnt_inc;

  function automatic logic [NMAX-1:0] drop_top(input logic [NMAX-1:0] v);
    logic found;
    drop_top = v;
    found    = 1'b0;
    for (int k = NMAX - 1; k >= 0; k--) begin
      if (v[k] && !found) begin
        drop_top[k] = 1'b0;
        found       = 1'b1;
      end
    end
  endfunction

  function automatic logic [NMAX-1:0] onehot(input logic [IW-1:0] i);
    onehot = '0;
    for (int k = 0; k < NMAX; k++) if (IW'(k) == i) onehot[k] = 1'b1;
  endfunction

  function automatic logic pick(input logic [NMAX-1:0] v, input logic [IW-1:0] i);
    pick = 1'b1;
    for (int k = 0; k < NMAX; k++) if (IW'(k) == i) pick = v[k];
  endfunction

  // Ack loss only counts for stages that finished settling; DOWN states ignore acks entirely.
  assign in_down  = (state_q == S_SB_DOWN) || (state_q == S_HV_DOWN);
  assign is_hv    = (state_q == S_HV_RAMP);
  assign cur_ack  = is_hv ? pick(NMAX'(i_Not_HV_ACK), idx_q) : pick(NMAX'(i_Not_SB_ACK), idx_q);
  assign cur_last = is_hv ? IW'(N_HV - 1) : IW'(N_SB - 1);
  assign cnt_inc  = (cnt_q == CW'(CMAX)) ? cnt_q : cnt_q + CW'(1);

  assign sb_trip = (state_q != S_OFF) && (state_q != S_FAULT) &&
                   (!i_Not_ANY_SB_GO_OFF || (!in_down && |(sb_done_q & i_Not_SB_ACK)));
  assign timeout = ((state_q == S_SB_RAMP) || is_hv) && !settle_q && cur_ack &&
                   (cnt_q >= CW'(TIMEOUT_CYC - 1));
  assign hv_trip = ((state_q == S_HV_RAMP) || (state_q == S_HV_ON) || (state_q == S_HV_DOWN)) &&
                   (!i_Not_ANY_HV_GO_OFF || (!in_down && |(hv_done_q & i_Not_HV_ACK)));

  always_ff @(posedge clk) begin
    // NOTE: no storage arrays here, so every register is reset synchronously.
    if (reset) begin
      state_q    <= S_OFF;
      code_q     <= FC_NONE;
      idx_q      <= '0;
      cnt_q      <= '0;
      settle_q   <= 1'b0;
      sb_en_q    <= '0;
      hv_en_q    <= '0;
      sb_done_q  <= '0;
      hv_done_q  <= '0;
      sb_on_n_q  <= 1'b1;
      sb_off_n_q <= 1'b1;
      hv_on_n_q  <= 1'b1;
      hv_off_n_q <= 1'b1;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
      state_q    <= state_d;
      code_q     <= code_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      settle_q   <= settle_d;
      sb_en_q    <= sb_en_d;
      hv_en_q    <= hv_en_d;
      sb_done_q  <= sb_done_d;
      hv_done_q  <= hv_done_d;
      sb_on_n_q  <= |i_Not_SB_ACK;
      sb_off_n_q <= ~&i_Not_SB_ACK;
      hv_on_n_q  <= |i_Not_HV_ACK;
      hv_off_n_q <= ~&i_Not_HV_ACK;
    end
  end

  always_comb begin
    // NOTE: every target gets a hold default first so no path can infer a latch.
    state_d   = state_q;
    code_d    = code_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    settle_d  = settle_q;
    sb_en_d   = sb_en_q;
    hv_en_d   = hv_en_q;
    sb_done_d = sb_done_q;
    hv_done_d = hv_done_q;

    if (sb_trip || timeout) begin
      state_d  = S_FAULT;
      code_d   = sb_trip ? FC_SB : FC_TIMEOUT;
      sb_en_d  = '0;
      hv_en_d  = '0;
      idx_d    = '0;
      cnt_d    = '0;
      settle_d = 1'b0;
    end else if (hv_trip) begin
      state_d  = S_FAULT_HV;
      code_d   = FC_HV;
      hv_en_d  = '0;
      idx_d    = '0;
      cnt_d    = '0;
      settle_d = 1'b0;
    end else begin
      unique case (state_q)
        S_OFF: begin
          if (sb_req && i_Not_ANY_SB_GO_OFF && i_Not_ANY_HV_GO_OFF) begin
            state_d  = S_SB_RAMP;
            idx_d    = '0;
            cnt_d    = '0;
            settle_d = 1'b0;
            sb_en_d  = N_SB'(onehot('0));
          end
        end
        S_SB_RAMP, S_HV_RAMP: begin
          if (!sb_req || (is_hv && !hv_req)) begin
            state_d  = is_hv ? S_HV_DOWN : S_SB_DOWN;
            cnt_d    = '0;
            settle_d = 1'b0;
            if (is_hv) hv_en_d = N_HV'(drop_top(NMAX'(hv_en_q)));
            else       sb_en_d = N_SB'(drop_top(NMAX'(sb_en_q)));
          end else if (!settle_q) begin
            if (!cur_ack) begin
              settle_d = 1'b1;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (cnt_q >= CW'(SETTLE_CYC)) begin
            settle_d = 1'b0;
            cnt_d    = '0;
            if (is_hv) hv_done_d = hv_done_q | N_HV'(onehot(idx_q));
            else       sb_done_d = sb_done_q | N_SB'(onehot(idx_q));
            if (idx_q == cur_last) begin
              state_d = is_hv ? S_HV_ON : S_SB_READY;
            end else begin
              idx_d = idx_q + IW'(1);
              if (is_hv) hv_en_d = hv_en_q | N_HV'(onehot(idx_q + IW'(1)));
              else       sb_en_d = sb_en_q | N_SB'(onehot(idx_q + IW'(1)));
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_SB_READY: begin
          if (!sb_req) begin
            state_d = S_SB_DOWN;
            cnt_d   = '0;
            sb_en_d = N_SB'(drop_top(NMAX'(sb_en_q)));
          end else if (hv_req) begin
            state_d  = S_HV_RAMP;
            idx_d    = '0;
            cnt_d    = '0;
            settle_d = 1'b0;
            hv_en_d  = N_HV'(onehot('0));
          end
        end
        S_HV_ON: begin
          if (!sb_req || !hv_req) begin
            state_d = S_HV_DOWN;
            cnt_d   = '0;
            hv_en_d = N_HV'(drop_top(NMAX'(hv_en_q)));
          end
        end
        S_HV_DOWN: begin
          if (hv_en_q == '0) begin
            cnt_d = '0;
            if (!sb_req) begin
              state_d = S_SB_DOWN;
              sb_en_d = N_SB'(drop_top(NMAX'(sb_en_q)));
            end else begin
              state_d = S_SB_READY;
            end
          end else if (cnt_q >= CW'(DROP_LAST)) begin
            cnt_d   = '0;
            hv_en_d = N_HV'(drop_top(NMAX'(hv_en_q)));
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_SB_DOWN: begin
          if (sb_en_q == '0) begin
            state_d = S_OFF;
            idx_d   = '0;
            cnt_d   = '0;
          end else if (cnt_q >= CW'(DROP_LAST)) begin
            cnt_d   = '0;
            sb_en_d = N_SB'(drop_top(NMAX'(sb_en_q)));
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_FAULT: begin
          if (fault_clr && !sb_req && !hv_req && i_Not_ANY_SB_GO_OFF && i_Not_ANY_HV_GO_OFF) begin
            state_d = S_OFF;
            code_d  = FC_NONE;
          end
        end
        S_FAULT_HV: begin
          if (fault_clr && !hv_req && i_Not_ANY_HV_GO_OFF) begin
            state_d = S_SB_READY;
            code_d  = FC_NONE;
          end
        end
        default: state_d = S_OFF;
      endcase
    end

    sb_done_d = sb_done_d & sb_en_d;
    hv_done_d = hv_done_d & hv_en_d;
  end

  // Both fault states read back as 7 on the 3-bit debug port; fault_code 3 marks FAULT_HV.
  always_comb begin
    fault = (state_q == S_FAULT) || (state_q == S_FAULT_HV);
    state = (state_q == S_FAULT_HV) ? 3'd7 : state_q[2:0];
  end

  assign sb_en        = sb_en_q;
  assign hv_en        = hv_en_q;
  assign o_Not_SB_ON  = sb_on_n_q;
  assign o_Not_SB_OFF = sb_off_n_q;
  assign o_Not_HV_ON  = hv_on_n_q;
  assign o_Not_HV_OFF = hv_off_n_q;
  assign fault_code   = code_q;

endmodule

// File: tb/tb_rpsc_seq_ctrl.sv
// Directed bench for rpsc_seq_ctrl. A stage-ack responder answers each enable two cycles later.
// Hand-computed expectations follow the edge numbering in each step's comments.
module tb_rpsc_seq_ctrl;

  localparam int N_SB = 4;
  localparam int N_HV = 2;

  localparam logic [2:0] ST_OFF = 3'd0, ST_SB_RAMP = 3'd1, ST_SB_READY = 3'd2,
                         ST_HV_RAMP = 3'd4, ST_HV_ON = 3'd5, ST_HV_DOWN = 3'd6,
                         ST_FAULT = 3'd7;

  logic            clk;
  logic            reset, sb_req, hv_req, fault_clr, go_sb, go_hv;
  logic [N_SB-1:0] i_Not_SB_ACK, sb_en, sb_hold;
  logic [N_HV-1:0] i_Not_HV_ACK, hv_en, hv_hold;
  logic            o_Not_SB_ON, o_Not_SB_OFF, o_Not_HV_ON, o_Not_HV_OFF, fault;
  logic [1:0]      fault_code;
  logic [2:0]      state;

  int n_cmp = 0;
  int n_err = 0;
  int sb_age [N_SB];
  int hv_age [N_HV];

  rpsc_seq_ctrl #(
    .N_SB(N_SB), .N_HV(N_HV), .SETTLE_CYC(4), .TIMEOUT_CYC(10)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .sb_req              (sb_req),
    .hv_req              (hv_req),
    .fault_clr           (fault_clr),
    .i_Not_SB_ACK        (i_Not_SB_ACK),
    .i_Not_HV_ACK        (i_Not_HV_ACK),
    .i_Not_ANY_SB_GO_OFF (go_sb),
    .i_Not_ANY_HV_GO_OFF (go_hv),
    .sb_en               (sb_en),
    .hv_en               (hv_en),
    .o_Not_SB_ON         (o_Not_SB_ON),
    .o_Not_SB_OFF        (o_Not_SB_OFF),
    .o_Not_HV_ON         (o_Not_HV_ON),
    .o_Not_HV_OFF        (o_Not_HV_OFF),
    .fault               (fault),
    .fault_code          (fault_code),
    .state               (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // Stage responder: ack goes low at the negedge after an enable has been high for two edges.
  initial begin
    i_Not_SB_ACK = '1;
    i_Not_HV_ACK = '1;
    for (int i = 0; i < N_SB; i++) sb_age[i] = 0;
    for (int i = 0; i < N_HV; i++) hv_age[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N_SB; i++) begin
        sb_age[i]       = sb_en[i] ? sb_age[i] + 1 : 0;
        i_Not_SB_ACK[i] = !(sb_age[i] >= 2 && !sb_hold[i]);
      end
      for (int i = 0; i < N_HV; i++) begin
        hv_age[i]       = hv_en[i] ? hv_age[i] + 1 : 0;
        i_Not_HV_ACK[i] = !(hv_age[i] >= 2 && !hv_hold[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; sb_req = 1'b0; hv_req = 1'b0; fault_clr = 1'b0;
    go_sb = 1'b1; go_hv = 1'b1; sb_hold = '0; hv_hold = '0;

    // Reset state, sampled while reset is still held
    repeat (3) tick();
    check("rst_state", state, ST_OFF);
    check("rst_sb_en", sb_en, 4'b0000);
    check("rst_hv_en", hv_en, 2'b00);
    check("rst_status", {o_Not_SB_ON, o_Not_SB_OFF, o_Not_HV_ON, o_Not_HV_OFF}, 4'b1111);
    check("rst_fault", {fault, fault_code}, 3'b000);

    reset = 1'b0;
    tick();
    check("idle_status", {o_Not_SB_ON, o_Not_SB_OFF, o_Not_HV_ON, o_Not_HV_OFF}, 4'b1010);

    // 1: full standby ramp, E0 = edge that samples sb_req
    sb_req = 1'b1;
    tick();
    check("t1_e0_en", sb_en, 4'b0001);
    check("t1_e0_state", state, ST_SB_RAMP);
    repeat (6) tick();
    check("t1_e6_en", sb_en, 4'b0001);
    tick();
    check("t1_e7_en", sb_en, 4'b0011);
    repeat (7) tick();
    check("t1_e14_en", sb_en, 4'b0111);
    repeat (7) tick();
    check("t1_e21_en", sb_en, 4'b1111);
    tick();
    check("t1_e22_sb_on", o_Not_SB_ON, 1'b1);
    tick();
    check("t1_e23_sb_on", o_Not_SB_ON, 1'b0);
    repeat (4) tick();
    check("t1_e27_state", state, ST_SB_RAMP);
    tick();
    check("t1_e28_state", state, ST_SB_READY);

    // 2: HV ramp then HV drop
    hv_req = 1'b1;
    tick();
    check("t2_h0_en", hv_en, 2'b01);
    check("t2_h0_state", state, ST_HV_RAMP);
    repeat (7) tick();
    check("t2_h7_en", hv_en, 2'b11);
    tick();
    check("t2_h8_hv_on", o_Not_HV_ON, 1'b1);
    tick();
    check("t2_h9_hv_on", o_Not_HV_ON, 1'b0);
    repeat (4) tick();
    check("t2_h13_state", state, ST_HV_RAMP);
    tick();
    check("t2_h14_state", state, ST_HV_ON);
    hv_req = 1'b0;
    tick();
    check("t2_d1_en", hv_en, 2'b01);
    check("t2_d1_state", state, ST_HV_DOWN);
    repeat (3) tick();
    check("t2_d4_en", hv_en, 2'b01);
    tick();
    check("t2_d5_en", hv_en, 2'b00);
    tick();
    check("t2_exit_state", state, ST_SB_READY);
    check("t2_exit_sb_en", sb_en, 4'b1111);

    // 4: HV trip in HV_ON, then clear back to SB_READY
    hv_req = 1'b1;
    tick();
    repeat (14) tick();
    check("t4_hv_on", state, ST_HV_ON);
    go_hv = 1'b0;
    tick();
    check("t4_trip_hv_en", hv_en, 2'b00);
    check("t4_trip_sb_en", sb_en, 4'b1111);
    check("t4_trip_code", {fault, fault_code}, 3'b111);
    go_hv = 1'b1;
    fault_clr = 1'b1;
    tick();
    check("t4_clr_ignored", {state, fault_code}, {ST_FAULT, 2'd3});
    hv_req = 1'b0;
    tick();
    check("t4_clr_state", state, ST_SB_READY);
    check("t4_clr_code", {fault, fault_code}, 3'b000);
    fault_clr = 1'b0;

    // 5: simultaneous SB and HV trip in HV_ON
    hv_req = 1'b1;
    tick();
    repeat (14) tick();
    check("t5_hv_on", state, ST_HV_ON);
    go_sb = 1'b0;
    go_hv = 1'b0;
    tick();
    check("t5_trip_state", state, ST_FAULT);
    check("t5_trip_code", {fault, fault_code}, 3'b101);
    check("t5_trip_en", {sb_en, hv_en}, 6'b000000);
    go_sb = 1'b1;
    go_hv = 1'b1;
    hv_req = 1'b0;
    fault_clr = 1'b1;
    tick();
    check("t5_clr_ignored", {state, fault_code}, {ST_FAULT, 2'd1});
    sb_req = 1'b0;
    tick();
    check("t5_clr_state", state, ST_OFF);
    check("t5_clr_code", {fault, fault_code}, 3'b000);
    fault_clr = 1'b0;

    // 3: stage 2 ack never returns; GO_OFF low in OFF first
    go_sb = 1'b0;
    sb_req = 1'b1;
    tick();
    check("t3_gooff_off", {state, fault}, {ST_OFF, 1'b0});
    go_sb = 1'b1;
    sb_hold = 4'b0100;
    tick();
    check("t3_e0_en", sb_en, 4'b0001);
    repeat (14) tick();
    check("t3_e14_en", sb_en, 4'b0111);
    repeat (9) tick();
    check("t3_e23_nofault", {state, fault}, {ST_SB_RAMP, 1'b0});
    tick();
    check("t3_e24_fault", {fault, fault_code}, 3'b110);
    check("t3_e24_en", sb_en, 4'b0000);
    sb_req = 1'b0;
    sb_hold = '0;
    fault_clr = 1'b1;
    tick();
    check("t3_clr_state", state, ST_OFF);
    fault_clr = 1'b0;

    // 6: reset in the middle of an HV ramp
    sb_req = 1'b1;
    tick();
    repeat (28) tick();
    check("t6_sb_ready", state, ST_SB_READY);
    hv_req = 1'b1;
    tick();
    repeat (3) tick();
    check("t6_hv_ramp", state, ST_HV_RAMP);
    reset = 1'b1;
    tick();
    check("t6_rst_en", {sb_en, hv_en}, 6'b000000);
    check("t6_rst_status", {o_Not_SB_ON, o_Not_SB_OFF, o_Not_HV_ON, o_Not_HV_OFF}, 4'b1111);
    check("t6_rst_state", {state, fault, fault_code}, {ST_OFF, 3'b000});
    reset = 1'b0;
    sb_req = 1'b0;
    hv_req = 1'b0;
    repeat (2) tick();
    check("t6_idle_state", state, ST_OFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
